bcd_serial_adder_ctrl: RTL and testbench
========================================

# bcd_serial_adder_ctrl

Digit-serial multi-digit BCD add/subtract engine. A single-digit BCD adder stage (4-bit binary add plus +6 correction) is time-shared across DIGITS packed BCD digits and sequenced LSD-first by an FSM with a registered inter-digit carry. It sits between a command source issuing start pulses and any consumer of packed BCD results, replacing a DIGITS-wide ripple of BCD adder stages with one stage and DIGITS cycles of latency.

## Interface
- DIGITS, 4, number of packed BCD digits per operand; legal range 2..16.
- clk  in  1  rising-edge clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request pulse; sampled every edge; accepted only in IDLE or DONE.
- op  in  1  0 = add (A+B+cin), 1 = subtract (A−B via nine's complement, cin ignored).
- a  in  4*DIGITS  operand A, packed BCD, digit 0 in [3:0]; captured on accepted start.
- b  in  4*DIGITS  operand B, same format; captured on accepted start.
- cin  in  1  carry-in for add; captured on accepted start.
- busy  out  1  high while digits are being processed (RUN).
- done  out  1  one-cycle pulse; sum/cout/err valid.
- sum  out  4*DIGITS  packed BCD result.
- cout  out  1  add: decimal carry-out; subtract: 1 = no borrow (A≥B).
- err  out  1  sticky per operation: some captured A or B digit > 9.

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE.
- IDLE: start=1 → capture a, b, op, cin; clear sum to 0, err to 0; digit index idx=0; carry = cin (add) or 1 (sub); → RUN. start=0 → stay.
- RUN, each edge, digit d=idx: bd = b digit (add) or (9 − b digit) mod 16 (sub); z = a_d + bd + carry (5-bit); if z > 9: sum digit d = (z+6)[3:0], carry=1; else sum digit d = z[3:0], carry=0. err |= (a_d>9)|(b_d>9), using the original, uncomplemented b digit. idx increments; after idx = DIGITS−1 is processed → DONE, cout = final carry.
- DONE: done=1 for exactly one cycle. start=1 → accepted as in IDLE (back-to-back), → RUN; else → IDLE.
- sum, cout, err hold their values from DONE until the next accepted start.
- start while in RUN: ignored, no queuing; operand inputs may change freely during RUN.
- Invalid digits: no saturation or abort. The correction rule above is applied verbatim and err is flagged.
- Subtract with cout=0: sum is the ten's complement of |A−B| (e.g., 0123−0500 → 9623).

## Timing
- Reset values: busy=0, done=0, sum=0, cout=0, err=0, idx=0, carry=0, state IDLE.
- rst is synchronous and has priority over all other activity. Reset during RUN aborts the operation: no done pulse, outputs return to reset values on the next edge.
- Start sampled high in cycle 0 → busy high in cycles 1..DIGITS → done high in cycle DIGITS+1, busy low in that cycle.
- Latency from start to done is DIGITS+1 cycles. Back-to-back throughput is one operation per DIGITS+1 cycles.
- sum digit d updates on the edge that processes it. Partial sums are visible during RUN but are defined only when done=1 or later.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- DIGITS=4, add, a=0x1234, b=0x5678, cin=0, start in cycle 0 → busy in cycles 1–4, done in cycle 5, sum=0x6912, cout=0, err=0.
- Add a=0x9999, b=0x0001, cin=0 → sum=0x0000, cout=1. Add a=0x0000, b=0x0000, cin=1 → sum=0x0001, cout=0.
- Subtract a=0x0500, b=0x0123 → sum=0x0377, cout=1. Immediately after, with start asserted in the DONE cycle, subtract a=0x0123, b=0x0500 → sum=0x9623, cout=0, done exactly 5 cycles after the first done.
- Invalid digit: add a=0x00A0, b=0x0000, cin=0 → sum=0x0100, cout=0, err=1. Next valid operation → err=0.
- Start pulsed in cycle 2 of RUN with different operands → ignored; result matches the first operands and only one done pulse occurs.
- rst asserted in cycle 2 of RUN → busy=0, sum=0, cout=0, err=0 on the next edge; no done pulse; a new start afterwards completes normally.

Source files
------------

// File: rtl/bcd_serial_adder_ctrl.sv
// bcd_serial_adder_ctrl: digit-serial packed-BCD add/subtract using one time-shared BCD digit stage
module bcd_serial_adder_ctrl #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  op,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    input  logic                  cin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   sum,
    output logic                  cout,
    output logic                  err
);
    localparam int IW = $clog2(DIGITS);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state, nxt;
    logic [4*DIGITS-1:0] a_r, b_r;
    logic                op_r, carry, gt, last, accept;
    logic [IW-1:0]       idx;
    logic [3:0]          a_d, b_d, bd, sd;
    logic [4:0]          z;

    // Single BCD digit stage on the digit selected by idx; subtract feeds the nine's complement of b
    always_comb begin
        a_d = a_r[idx*4 +: 4];
        b_d = b_r[idx*4 +: 4];
        bd  = op_r ? 4'd9 - b_d : b_d;
        z   = {1'b0, a_d} + {1'b0, bd} + {4'b0, carry};
        gt  = z > 5'd9;
        sd  = z[3:0] + (gt ? 4'd6 : 4'd0);
    end

    // Next state: a start is taken whenever not mid-operation, which gives back-to-back from DONE
    always_comb begin
        last   = idx == IW'(DIGITS - 1);
        accept = start && state != RUN;
        nxt    = state == RUN ? (last ? DONE : RUN) : (start ? RUN : IDLE);
        busy   = state == RUN;
        done   = state == DONE;
    end

    // State, operand capture and per-digit result/carry/error update
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            a_r   <= '0;
            b_r   <= '0;
            op_r  <= 1'b0;
            carry <= 1'b0;
            idx   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= nxt;
            if (accept) begin
                a_r   <= a;
                b_r   <= b;
                op_r  <= op;
                carry <= op ? 1'b1 : cin;
                idx   <= '0;
                sum   <= '0;
                err   <= 1'b0;
            end else if (state == RUN) begin
                sum[idx*4 +: 4] <= sd;
                carry           <= gt;
                err             <= err | (a_d > 4'd9) | (b_d > 4'd9);
                idx             <= idx + 1'b1;
                if (last)
                    cout <= gt;
            end
        end
    end
endmodule

// File: tb/tb_bcd_serial_adder_ctrl.sv
// tb_bcd_serial_adder_ctrl: directed vectors checked against a decimal-arithmetic model every cycle
module tb_bcd_serial_adder_ctrl;
    localparam int D = 4;
    localparam int W = 4 * D;

    logic         clk = 0, rst = 1, start = 0, op = 0, cin = 0;
    logic [W-1:0] a = '0, b = '0;
    logic         busy, done, cout, err;
    logic [W-1:0] sum;

    int errors = 0, checks = 0;
    bit go = 0;

    int           ph = 0;
    logic [W-1:0] ms = '0, ps = '0;
    logic         mc = 0, me = 0, pc = 0, pe = 0;

    bcd_serial_adder_ctrl #(.DIGITS(D)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Decimal value arithmetic when all digits are valid; the digit rule applied literally otherwise
    function automatic void model(input logic [W-1:0] x, input logic [W-1:0] y, input logic o,
                                  input logic c, output logic [W-1:0] s, output logic co,
                                  output logic er);
        longint xa = 0, yb = 0, p = 1, r;
        int cy;
        er = 0;
        for (int i = 0; i < D; i++)
            er |= (x[i*4 +: 4] > 9) | (y[i*4 +: 4] > 9);
        s = '0;
        if (!er) begin
            for (int i = D - 1; i >= 0; i--) begin
                xa = xa * 10 + longint'(x[i*4 +: 4]);
                yb = yb * 10 + longint'(y[i*4 +: 4]);
                p  = p * 10;
            end
            r  = o ? xa - yb + p : xa + yb + longint'(c);
            co = r >= p;
            r  = r % p;
            for (int i = 0; i < D; i++) begin
                s[i*4 +: 4] = 4'(r % 10);
                r = r / 10;
            end
        end else begin
            cy = o ? 1 : int'(c);
            for (int i = 0; i < D; i++) begin
                int t;
                t = int'(x[i*4 +: 4]) + (o ? (9 - int'(y[i*4 +: 4])) & 15 : int'(y[i*4 +: 4])) + cy;
                if (t > 9) begin
                    s[i*4 +: 4] = 4'(t + 6);
                    cy = 1;
                end else begin
                    s[i*4 +: 4] = 4'(t);
                    cy = 0;
                end
            end
            co = cy[0];
        end
    endfunction

    // Model: phase 0 idle, 1..D running, D+1 done
    always @(posedge clk) begin
        if (rst) begin
            ph = 0; ms = '0; mc = 0; me = 0;
        end else if ((ph == 0 || ph == D + 1) && start) begin
            model(a, b, op, cin, ps, pc, pe);
            ph = 1;
        end else if (ph >= 1 && ph <= D) begin
            ph++;
            if (ph == D + 1) begin
                ms = ps; mc = pc; me = pe;
            end
        end else begin
            ph = 0;
        end
    end

    // Compare DUT against the model every cycle; results only when they are defined
    always @(negedge clk) begin
        if (go) begin
            chk("busy", 64'(busy), 64'(ph >= 1 && ph <= D));
            chk("done", 64'(done), 64'(ph == D + 1));
            if (ph == 0 || ph == D + 1) begin
                chk("sum", 64'(sum), 64'(ms));
                chk("cout", 64'(cout), 64'(mc));
                chk("err", 64'(err), 64'(me));
            end
        end
    end

    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic o, input logic c);
        a = x; b = y; op = o; cin = c; start = 1;
        @(negedge clk);
        start = 0;
    endtask

    task automatic wait_done(input int n0, input logic [W-1:0] es, input logic ec, input logic ee,
                             input string nm);
        int n;
        n = n0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_latency"}, 64'(n), 64'(D + 1));
        chk({nm, "_sum"}, 64'(sum), 64'(es));
        chk({nm, "_cout"}, 64'(cout), 64'(ec));
        chk({nm, "_err"}, 64'(err), 64'(ee));
    endtask

    initial begin
        repeat (2) @(negedge clk);
        go = 1;
        chk("reset_busy", 64'(busy), 64'(0));
        chk("reset_sum", 64'(sum), 64'(0));
        rst = 0;
        @(negedge clk);

        issue(16'h1234, 16'h5678, 0, 0);
        chk("busy_cycle1", 64'(busy), 64'(1));
        wait_done(1, 16'h6912, 0, 0, "add1");
        @(negedge clk);
        chk("done_one_cycle", 64'(done), 64'(0));

        issue(16'h9999, 16'h0001, 0, 0);
        wait_done(1, 16'h0000, 1, 0, "add_carry");
        issue(16'h0000, 16'h0000, 0, 1);
        wait_done(1, 16'h0001, 0, 0, "add_cin");

        issue(16'h0500, 16'h0123, 1, 0);
        wait_done(1, 16'h0377, 1, 0, "sub_pos");
        issue(16'h0123, 16'h0500, 1, 0);
        wait_done(1, 16'h9623, 0, 0, "sub_b2b");

        issue(16'h00A0, 16'h0000, 0, 0);
        wait_done(1, 16'h0100, 0, 1, "invalid");
        issue(16'h0042, 16'h0017, 0, 0);
        wait_done(1, 16'h0059, 0, 0, "err_clear");

        issue(16'h2468, 16'h1357, 0, 0);
        @(negedge clk);
        a = 16'h9999; b = 16'h9999; op = 1; start = 1;
        @(negedge clk);
        start = 0;
        wait_done(3, 16'h3825, 0, 0, "ignored_start");
        repeat (3) @(negedge clk);

        issue(16'h4321, 16'h1111, 0, 0);
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_sum", 64'(sum), 64'(0));
        chk("abort_cout", 64'(cout), 64'(0));
        chk("abort_err", 64'(err), 64'(0));
        repeat (6) @(negedge clk);
        issue(16'h0999, 16'h0001, 0, 0);
        wait_done(1, 16'h1000, 0, 0, "after_reset");
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
